// File: rtl/wb_port_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : wb_port_arbiter
//  Description : Shares the register-file write port between the pipeline
//                write-back path and a multi-cycle unit via a one-entry
//                buffer with a bounded-wait forced stall.
//                Optional statistics counters: define WB_ARB_STATS_EN.
//  Revision    : 1.0 - initial release
// ============================================================================
module wb_port_arbiter #(
    parameter int MAX_WAIT = 4,
    parameter int DW       = 32,
    parameter int AW       = 5
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          pipe_reg_write,
    input  logic [AW-1:0] pipe_rd,
    input  logic [DW-1:0] pipe_data,
    input  logic          mc_valid,
    input  logic [AW-1:0] mc_rd,
    input  logic [DW-1:0] mc_data,
    output logic          mc_ready,
    output logic          stall,
    output logic          rf_we,
    output logic [AW-1:0] rf_waddr,
    output logic [DW-1:0] rf_wdata
`ifdef WB_ARB_STATS_EN
    ,
    output logic [15:0]   force_count,
    output logic [15:0]   drop_count
`endif
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        PEND  = 2'd1,
        FORCE = 2'd2
    } state_t;

    localparam logic [3:0] C_WAIT_LAST = 4'(MAX_WAIT - 1);

    state_t        r_state;
    logic [3:0]    r_wait_cnt;
    logic [AW-1:0] r_buf_rd;
    logic [DW-1:0] r_buf_data;

    logic          w_same_rd;

    assign w_same_rd = pipe_reg_write && (pipe_rd == r_buf_rd);
    assign mc_ready  = (r_state == IDLE);
    assign stall     = (r_state == FORCE);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state    <= IDLE;
            r_wait_cnt <= 4'd0;
            r_buf_rd   <= '0;
            r_buf_data <= '0;
            rf_we      <= 1'b0;
            rf_waddr   <= '0;
            rf_wdata   <= '0;
        end else begin
            rf_we <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (pipe_reg_write) begin
                        rf_we    <= (pipe_rd != '0);
                        rf_waddr <= pipe_rd;
                        rf_wdata <= pipe_data;
                    end
                    // An mc result targeting r0 is accepted and simply dropped
                    if (mc_valid && (mc_rd != '0)) begin
                        r_buf_rd   <= mc_rd;
                        r_buf_data <= mc_data;
                        r_state    <= PEND;
                    end
                end
                PEND: begin
                    if (pipe_reg_write) begin
                        rf_we    <= (pipe_rd != '0);
                        rf_waddr <= pipe_rd;
                        rf_wdata <= pipe_data;
                        if (w_same_rd) begin
                            // Younger pipeline write supersedes the buffered one
                            r_state    <= IDLE;
                            r_wait_cnt <= 4'd0;
                        end else if (r_wait_cnt == C_WAIT_LAST) begin
                            r_state    <= FORCE;
                            r_wait_cnt <= 4'd0;
                        end else if (r_wait_cnt != 4'hF) begin
                            r_wait_cnt <= r_wait_cnt + 4'd1;
                        end
                    end else begin
                        rf_we      <= 1'b1;
                        rf_waddr   <= r_buf_rd;
                        rf_wdata   <= r_buf_data;
                        r_state    <= IDLE;
                        r_wait_cnt <= 4'd0;
                    end
                end
                FORCE: begin
                    rf_we      <= 1'b1;
                    rf_waddr   <= r_buf_rd;
                    rf_wdata   <= r_buf_data;
                    r_state    <= IDLE;
                    r_wait_cnt <= 4'd0;
                end
                default: begin
                    r_state    <= IDLE;
                    r_wait_cnt <= 4'd0;
                end
            endcase
        end
    end

`ifdef WB_ARB_STATS_EN
    logic w_force_evt;
    logic w_drop_evt;

    assign w_force_evt = (r_state == PEND) && pipe_reg_write && !w_same_rd
                         && (r_wait_cnt == C_WAIT_LAST);
    assign w_drop_evt  = (r_state == PEND) && w_same_rd;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            force_count <= 16'd0;
            drop_count  <= 16'd0;
        end else begin
            if (w_force_evt && (force_count != 16'hFFFF))
                force_count <= force_count + 16'd1;
            if (w_drop_evt && (drop_count != 16'hFFFF))
                drop_count <= drop_count + 16'd1;
        end
    end
`endif

endmodule
`default_nettype wire

// File: tb/tb_wb_port_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_wb_port_arbiter
//  Description : Directed self-checking bench for wb_port_arbiter.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_wb_port_arbiter;

    logic        clk;
    logic        rst;
    logic        pipe_reg_write;
    logic [4:0]  pipe_rd;
    logic [31:0] pipe_data;
    logic        mc_valid;
    logic [4:0]  mc_rd;
    logic [31:0] mc_data;
    logic        mc_ready;
    logic        stall;
    logic        rf_we;
    logic [4:0]  rf_waddr;
    logic [31:0] rf_wdata;
`ifdef WB_ARB_STATS_EN
    logic [15:0] force_count;
    logic [15:0] drop_count;
`endif

    int r_tests;
    int r_fails;

    wb_port_arbiter #(.MAX_WAIT(4), .DW(32), .AW(5)) dut (
        .clk            (clk),
        .rst            (rst),
        .pipe_reg_write (pipe_reg_write),
        .pipe_rd        (pipe_rd),
        .pipe_data      (pipe_data),
        .mc_valid       (mc_valid),
        .mc_rd          (mc_rd),
        .mc_data        (mc_data),
        .mc_ready       (mc_ready),
        .stall          (stall),
        .rf_we          (rf_we),
        .rf_waddr       (rf_waddr),
        .rf_wdata       (rf_wdata)
`ifdef WB_ARB_STATS_EN
        ,
        .force_count    (force_count),
        .drop_count     (drop_count)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        r_tests++;
        if (obs !== exp) begin
            r_fails++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        pipe_reg_write = 1'b0;
        pipe_rd        = '0;
        pipe_data      = '0;
        mc_valid       = 1'b0;
        mc_rd          = '0;
        mc_data        = '0;
    endtask

    // Buffers an mc result for rd 9 and lets the pipe win four times -> FORCE
    task automatic run_to_force(input logic [31:0] base);
        mc_valid = 1'b1; mc_rd = 5'd9; mc_data = 32'h0000_0099;
        step();
        check("buf_mc_ready", {31'd0, mc_ready}, 32'd0);
        mc_valid = 1'b0;
        for (int i = 0; i < 4; i++) begin
            pipe_reg_write = 1'b1; pipe_rd = 5'd1; pipe_data = base + 32'(i);
            step();
            check("force_pipe_we",    {31'd0, rf_we}, 32'd1);
            check("force_pipe_addr",  {27'd0, rf_waddr}, 32'd1);
            check("force_pipe_data",  rf_wdata, base + 32'(i));
            check("force_stall",      {31'd0, stall}, (i == 3) ? 32'd1 : 32'd0);
        end
    endtask

    initial begin
        r_tests = 0;
        r_fails = 0;
        rst = 1'b0;
        idle_inputs();
        step();
        step();
        check("rst_mc_ready", {31'd0, mc_ready}, 32'd1);
        check("rst_stall",    {31'd0, stall}, 32'd0);
        check("rst_we",       {31'd0, rf_we}, 32'd0);
        check("rst_waddr",    {27'd0, rf_waddr}, 32'd0);
        check("rst_wdata",    rf_wdata, 32'd0);
        @(negedge clk);
        rst = 1'b1;

        // Pipe only
        pipe_reg_write = 1'b1; pipe_rd = 5'd3; pipe_data = 32'hA5A5_0001;
        step();
        check("pipe_we",       {31'd0, rf_we}, 32'd1);
        check("pipe_waddr",    {27'd0, rf_waddr}, 32'd3);
        check("pipe_wdata",    rf_wdata, 32'hA5A5_0001);
        check("pipe_mc_ready", {31'd0, mc_ready}, 32'd1);
        check("pipe_stall",    {31'd0, stall}, 32'd0);
        idle_inputs();
        step();
        check("pipe_off_we", {31'd0, rf_we}, 32'd0);

        // Idle-slot drain
        mc_valid = 1'b1; mc_rd = 5'd7; mc_data = 32'h0000_BEEF;
        step();
        check("drain_mc_ready_lo", {31'd0, mc_ready}, 32'd0);
        check("drain_we_lo",       {31'd0, rf_we}, 32'd0);
        idle_inputs();
        step();
        check("drain_we",          {31'd0, rf_we}, 32'd1);
        check("drain_waddr",       {27'd0, rf_waddr}, 32'd7);
        check("drain_wdata",       rf_wdata, 32'h0000_BEEF);
        check("drain_mc_ready_hi", {31'd0, mc_ready}, 32'd1);
        step();
        check("drain_once", {31'd0, rf_we}, 32'd0);

        // Forced stall: 4 pipe wins, one stall, buffered write, then 5th pipe write
        run_to_force(32'h0000_0101);
        pipe_data = 32'h0000_0105;
        step();
        check("force_buf_we",    {31'd0, rf_we}, 32'd1);
        check("force_buf_addr",  {27'd0, rf_waddr}, 32'd9);
        check("force_buf_data",  rf_wdata, 32'h0000_0099);
        check("force_one_stall", {31'd0, stall}, 32'd0);
        check("force_mc_ready",  {31'd0, mc_ready}, 32'd1);
        step();
        check("force_resume_addr", {27'd0, rf_waddr}, 32'd1);
        check("force_resume_data", rf_wdata, 32'h0000_0105);
        idle_inputs();
        step();
        check("force_resume_once", {31'd0, rf_we}, 32'd0);

        // Same-rd discard
        mc_valid = 1'b1; mc_rd = 5'd5; mc_data = 32'h0000_1111;
        step();
        mc_valid = 1'b0;
        pipe_reg_write = 1'b1; pipe_rd = 5'd5; pipe_data = 32'h0000_2222;
        step();
        check("same_waddr",    {27'd0, rf_waddr}, 32'd5);
        check("same_wdata",    rf_wdata, 32'h0000_2222);
        check("same_mc_ready", {31'd0, mc_ready}, 32'd1);
        check("same_stall",    {31'd0, stall}, 32'd0);
        idle_inputs();
        step();
        check("same_no_stale", {31'd0, rf_we}, 32'd0);
`ifdef WB_ARB_STATS_EN
        check("stats_drop_1",  {16'd0, drop_count}, 32'd1);
        check("stats_force_1", {16'd0, force_count}, 32'd1);
`endif

        // Register 0
        pipe_reg_write = 1'b1; pipe_rd = 5'd0; pipe_data = 32'hFFFF_FFFF;
        mc_valid = 1'b1; mc_rd = 5'd0; mc_data = 32'hFFFF_FFFF;
        step();
        check("r0_we",       {31'd0, rf_we}, 32'd0);
        check("r0_mc_ready", {31'd0, mc_ready}, 32'd1);
        idle_inputs();
        step();
        check("r0_we_after", {31'd0, rf_we}, 32'd0);

        // Asynchronous reset while in FORCE
        run_to_force(32'h0000_0201);
        idle_inputs();
        #2;
        rst = 1'b0;
        #1;
        check("arst_stall",    {31'd0, stall}, 32'd0);
        check("arst_we",       {31'd0, rf_we}, 32'd0);
        check("arst_mc_ready", {31'd0, mc_ready}, 32'd1);
        check("arst_wait_cnt", {28'd0, dut.r_wait_cnt}, 32'd0);
`ifdef WB_ARB_STATS_EN
        check("arst_force_cnt", {16'd0, force_count}, 32'd0);
        check("arst_drop_cnt",  {16'd0, drop_count}, 32'd0);
`endif
        @(negedge clk);
        rst = 1'b1;
        step();
        check("arst_no_partial", {31'd0, rf_we}, 32'd0);
`ifdef WB_ARB_STATS_EN
        run_to_force(32'h0000_0301);
        idle_inputs();
        step();
        check("stats_force_after", {16'd0, force_count}, 32'd1);
`endif

        $display("[TB] %0d tests run, %0d failed", r_tests, r_fails);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/wb_port_arbiter.md
Name: wb_port_arbiter

Overview:
- Shares the single register-file write port between two sources.
  - The pipeline write-back path: the 32-bit output of the WB-stage mux, plus its destination register and write enable.
  - A long-latency multi-cycle unit (mul/div), which uses a valid/ready handshake.
- The pipeline always wins the port.
- The multi-cycle result waits in a one-entry holding buffer.
- If it waits too long, the arbiter freezes the pipeline for one cycle to force it through.

Parameters:
- MAX_WAIT, 4: cycles the pipeline may win while a buffered entry waits; after that a forced stall follows. Legal range 1..15.
- DW, 32: data width.
- AW, 5: register address width.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- pipe_reg_write  in  1  WB stage requests a register write this cycle.
- pipe_rd  in  AW  WB destination register.
- pipe_data  in  DW  WB data (write-back mux output).
- mc_valid  in  1  multi-cycle unit presents a result.
- mc_rd  in  AW  multi-cycle destination register.
- mc_data  in  DW  multi-cycle result.
- mc_ready  out  1  arbiter accepts the multi-cycle result.
- stall  out  1  freezes IF..WB for this cycle; the WB instruction is re-presented next cycle.
- rf_we  out  1  register-file write enable (registered).
- rf_waddr  out  AW  register-file write address (registered).
- rf_wdata  out  DW  register-file write data (registered).

Behaviour:
- Reset is asynchronous on rst low. Reset values:
  - state = IDLE, wait_cnt = 0.
  - rf_we = 0, rf_waddr = 0, rf_wdata = 0.
  - stall = 0, mc_ready = 1.
- State decodes (from the state register, no input paths):
  - mc_ready = (state == IDLE).
  - stall = (state == FORCE).
- Port latency: the granted write appears on rf_* one clock after the request cycle.
- Register 0 is never written:
  - A pipe write with pipe_rd == 0 gives rf_we = 0.
  - An accepted mc result with mc_rd == 0 is accepted and discarded; state stays IDLE.
- IDLE:
  - Pipe write granted if pipe_reg_write = 1.
  - mc_valid = 1 with mc_rd != 0: capture mc_rd and mc_data into the buffer, go to PEND.
  - The pipe grant happens in the same cycle regardless.
- PEND (mc_ready = 0):
  - pipe_reg_write = 1 and pipe_rd == buffered rd: pipe granted, buffered entry discarded (pipeline write is younger), go to IDLE, clear wait_cnt.
  - pipe_reg_write = 1 (other rd): pipe granted. If wait_cnt == MAX_WAIT-1, go to FORCE and clear wait_cnt; else increment wait_cnt.
  - pipe_reg_write = 0: buffer granted, go to IDLE, clear wait_cnt.
- FORCE (stall = 1):
  - Buffer granted unconditionally.
  - pipe_* is ignored, because the pipeline is frozen and re-presents next cycle.
  - Go to IDLE. Exactly one stall cycle per force.
- A new mc result is never accepted in the same cycle a buffered entry drains; acceptance resumes the cycle after IDLE is re-entered.
- Reset asserted mid-PEND or mid-FORCE: the buffered entry is lost; there is no partial write.
- wait_cnt is 4 bits and saturates; it never wraps, given the legal MAX_WAIT range.

Optional Feature:
- Macro: WB_ARB_STATS_EN.
- Defined:
  - Adds output port force_count (16-bit). It increments on every PEND->FORCE transition, saturates at 16'hFFFF, and resets to 0.
  - Adds output port drop_count (16-bit). It increments on every same-rd discard, saturates at 16'hFFFF, and resets to 0.
- Undefined: neither port nor counter exists; all other behaviour is identical.

Test Plan:
- Pipe only: pipe_reg_write = 1, rd = 3, data = 32'hA5A5_0001, IDLE. Next cycle rf_we = 1, rf_waddr = 3, rf_wdata = A5A5_0001. mc_ready stays 1 and stall stays 0.
- Idle slot drain: mc_valid = 1, rd = 7, data = 32'h0000_BEEF with the pipe idle. mc_ready drops, and the next cycle drains. rf_we = 1, rf_waddr = 7, rf_wdata = BEEF appears one clock after the drain cycle; mc_ready returns to 1.
- Forced stall: MAX_WAIT = 4, mc rd = 9 buffered, pipe writes rd = 1 every cycle.
  - Pipe wins 4 cycles, then stall = 1 for exactly 1 cycle.
  - rf_waddr = 9 follows that cycle.
  - Pipe writes resume with no lost write: each of the 5 pipe writes lands exactly once.
- Same-rd discard: buffer holds rd = 5, data = 32'h1111, then pipe writes rd = 5, data = 32'h2222. Only 32'h2222 reaches the register file; state returns to IDLE with no stall.
- Register 0: pipe rd = 0 and mc rd = 0, each with data FFFF_FFFF. rf_we stays 0 and mc_ready stays 1.
- Reset: assert rst = 0 asynchronously in FORCE. stall, rf_we and wait_cnt go to 0 immediately and mc_ready goes to 1. With WB_ARB_STATS_EN defined, force_count reads 0 after reset and 1 after one forced stall.
